// File: rtl/mem_bus_access_unit.sv
// mem_bus_access_unit: data-memory access stage behind the EX->MEM register.
// Turns the MEM-stage load/store controls into one request/acknowledge bus
// transaction and stalls the pipeline while that transaction is in flight.
//
// Handshake: bus_req, bus_we, bus_addr, bus_sel and bus_wdata are registered
// and held stable from the issue edge until the edge after bus_ack is sampled
// high in BUSY. bus_ack is a single-cycle pulse. bus_rdata is only looked at
// in the BUSY cycle where bus_ack=1. bus_ack outside BUSY is ignored.
//
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN. When defined, a BUSY cycle
// counter aborts the transaction after TIMEOUT_CYCLES cycles without an ack
// and pulses bus_error_out. When undefined, BUSY waits indefinitely and
// bus_error_out is tied low.
module mem_bus_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  global_flush,
    input  logic                  mem_enable_in,
    input  logic                  mem_rw_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [DATA_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] mem_write_in,
    output logic [DATA_WIDTH-1:0] mem_read_out,
    output logic                  stall_out,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_error_out,
    output logic [1:0]            state_dbg
);

    // Encoding of mem_rw_in: 1 = store, 0 = load.
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic is_write;
    logic issue;
    logic ack_seen;
    logic timeout_hit;
    logic discard_q;
    logic discard_now;

    // The counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in the range 1..255");
    end

    assign is_write = (mem_rw_in == MEM_WRITE);

    // A store with no byte lanes (misaligned SH) is a no-op: no request, no stall.
    assign issue = (state_q == IDLE) && mem_enable_in && !global_flush &&
                   !(is_write && (mem_sel_in == 4'b0000));

    assign ack_seen  = (state_q == BUSY) && bus_ack;

    // A flush in the ack cycle itself also drops the returning read data.
    assign discard_now = discard_q || global_flush;

    // Stall depends only on state and pipeline inputs, never on bus inputs.
    assign stall_out = issue || (state_q == BUSY);
    assign state_dbg = state_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] timeout_cnt;

    // Abort in the BUSY cycle that would bring the no-ack count to the limit;
    // an ack in that same cycle takes priority.
    assign timeout_hit = (state_q == BUSY) && !bus_ack &&
                         (({1'b0, timeout_cnt} + 9'd1) == TIMEOUT_LIMIT);

    // Count BUSY cycles without an ack; restart on every new transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (issue) begin
            timeout_cnt <= '0;
        end else if ((state_q == BUSY) && !bus_ack) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // One-cycle error pulse coinciding with the DONE cycle of an aborted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_error_out <= 1'b0;
        end else begin
            bus_error_out <= timeout_hit;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign bus_error_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on issue, BUSY -> DONE on ack/abort, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus request registers and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_sel      <= 4'b0000;
            bus_wdata    <= '0;
            mem_read_out <= '0;
        end else begin
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= is_write;
                bus_addr  <= {addr_in[DATA_WIDTH-1:2], 2'b00};
                bus_sel   <= is_write ? mem_sel_in : 4'b1111;
                bus_wdata <= mem_write_in;
            end else if (ack_seen || timeout_hit) begin
                bus_req <= 1'b0;
            end
            if (ack_seen && !bus_we && !discard_now) begin
                mem_read_out <= bus_rdata;
            end
        end
    end

    // Discard flag: set by a flush during BUSY, cleared on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_q <= 1'b0;
        end else if (state_q == DONE) begin
            discard_q <= 1'b0;
        end else if ((state_q == BUSY) && global_flush) begin
            discard_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_access_unit.sv
// Bench for mem_bus_access_unit: table of load/store transactions with
// hand-computed bus fields, stall/request cycle counts and read results,
// followed by hand-written sequences for ack-outside-BUSY and mid-BUSY reset.
module tb_mem_bus_access_unit;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          global_flush;
    logic          mem_enable_in;
    logic          mem_rw_in;
    logic [3:0]    mem_sel_in;
    logic [DW-1:0] addr_in;
    logic [DW-1:0] mem_write_in;
    logic [DW-1:0] mem_read_out;
    logic          stall_out;
    logic          bus_req;
    logic          bus_we;
    logic [DW-1:0] bus_addr;
    logic [3:0]    bus_sel;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          bus_error_out;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] model_read = '0;

    mem_bus_access_unit #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .global_flush (global_flush),
        .mem_enable_in(mem_enable_in),
        .mem_rw_in    (mem_rw_in),
        .mem_sel_in   (mem_sel_in),
        .addr_in      (addr_in),
        .mem_write_in (mem_write_in),
        .mem_read_out (mem_read_out),
        .stall_out    (stall_out),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_error_out(bus_error_out),
        .state_dbg    (state_dbg)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rw;        // 1 = store
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // returned with the ack
        int          wait_n;    // BUSY cycles before the ack cycle
        int          flush_at;  // -2 none, -1 in issue cycle, k in BUSY cycle k
        logic        exp_issue;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        logic        exp_we;
        int          exp_req;   // cycles with bus_req high
        int          exp_stall; // cycles with stall_out high
        logic        upd;       // read result becomes visible on mem_read_out
        logic        exp_err;   // error pulse in the DONE cycle
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one transaction starting at the next rising edge and act as the slave.
    task automatic run_op(input int id, input vec_t v);
        int   busy_n;
        int   stall_n;
        logic done_seen;
        @(posedge clk); #1;
        mem_enable_in = v.en;
        mem_rw_in     = v.rw;
        mem_sel_in    = v.sel;
        addr_in       = v.addr;
        mem_write_in  = v.wdata;
        global_flush  = (v.flush_at == -1);
        bus_ack       = 1'b0;
        bus_rdata     = $urandom;
        #5;
        chk($sformatf("v%0d issue_stall", id), {31'b0, stall_out}, {31'b0, v.exp_issue});
        chk($sformatf("v%0d issue_err", id), {31'b0, bus_error_out}, 32'd0);
        busy_n    = 0;
        stall_n   = stall_out ? 1 : 0;
        done_seen = 1'b0;
        if (v.upd) model_read = v.rdata;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(posedge clk); #1;
            mem_enable_in = 1'b0;
            global_flush  = bus_req && (busy_n == v.flush_at);
            if (bus_req && (busy_n == v.wait_n)) begin
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
            #5;
            if (stall_out) stall_n++;
            if (bus_req) begin
                busy_n++;
                chk($sformatf("v%0d bus_addr", id), bus_addr, v.exp_addr);
                chk($sformatf("v%0d bus_sel", id), {28'b0, bus_sel}, {28'b0, v.exp_sel});
                chk($sformatf("v%0d bus_we", id), {31'b0, bus_we}, {31'b0, v.exp_we});
                chk($sformatf("v%0d bus_wdata", id), bus_wdata, v.wdata);
            end
            if (state_dbg == 2'd2) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d done_stall", id), {31'b0, stall_out}, 32'd0);
                chk($sformatf("v%0d done_req", id), {31'b0, bus_req}, 32'd0);
                chk($sformatf("v%0d read_out", id), mem_read_out, model_read);
                chk($sformatf("v%0d done_err", id), {31'b0, bus_error_out}, {31'b0, v.exp_err});
            end else begin
                chk($sformatf("v%0d err_low", id), {31'b0, bus_error_out}, 32'd0);
            end
            if (!v.exp_issue && c == 3) break;
        end
        bus_ack      = 1'b0;
        global_flush = 1'b0;
        chk($sformatf("v%0d done_seen", id), {31'b0, done_seen}, {31'b0, v.exp_issue});
        chk($sformatf("v%0d req_cycles", id), busy_n, v.exp_req);
        chk($sformatf("v%0d stall_cycles", id), stall_n, v.exp_stall);
        if (!v.exp_issue) chk($sformatf("v%0d read_hold", id), mem_read_out, model_read);
    endtask

    initial begin
        //        en   rw    sel      addr          wdata         rdata         wait fl  iss  exp_addr      sel      we   req stl upd  err
        vecs[0] = '{1'b1, 1'b0, 4'b1111, 32'h1000_0006, 32'h0,        32'hCAFE_BABE, 0, -2, 1'b1, 32'h1000_0004, 4'b1111, 1'b0, 1, 2, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 3, -2, 1'b1, 32'h0000_0020, 4'b0100, 1'b1, 4, 5, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'b0000, 32'h0000_0021, 32'h7777_7777, 32'h0,         0, -2, 1'b0, 32'h0,         4'b0000, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 4'b0000, 32'h0000_0103, 32'h0,        32'h0BAD_F00D, 1, -2, 1'b1, 32'h0000_0100, 4'b1111, 1'b0, 2, 3, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h1122_3344, 32'h0,         2, -2, 1'b1, 32'hFFFF_FFFC, 4'b1111, 1'b1, 3, 4, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0040, 32'h0,        32'h0000_1234, 2,  1, 1'b1, 32'h0000_0040, 4'b1111, 1'b0, 3, 4, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0044, 32'h0,        32'h9999_9999, 0, -1, 1'b0, 32'h0,         4'b0000, 1'b0, 0, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'b0011, 32'h7FFF_FFFE, 32'h0,        32'h89AB_CDEF, 3, -2, 1'b1, 32'h7FFF_FFFC, 4'b1111, 1'b0, 4, 5, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 4'b1111, 32'h0000_0048, 32'h0,        32'h4444_4444, 0, -2, 1'b0, 32'h0,         4'b0000, 1'b0, 0, 0, 1'b0, 1'b0};
`ifdef MEM_ACCESS_TIMEOUT_EN
        // Slave never answers: abort after 4 BUSY cycles with an error pulse.
        vecs[9] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0500, 32'h0,        32'h0F0F_0F0F, 99, -2, 1'b1, 32'h0000_0500, 4'b1111, 1'b0, 4, 5, 1'b0, 1'b1};
`else
        // Long wait: no abort without the timeout feature.
        vecs[9] = '{1'b1, 1'b0, 4'b1111, 32'h0000_0500, 32'h0,        32'h0F0F_0F0F, 12, -2, 1'b1, 32'h0000_0500, 4'b1111, 1'b0, 13, 14, 1'b1, 1'b0};
`endif
        vecs[10] = '{1'b1, 1'b1, 4'b1001, 32'h0000_0602, 32'hA1B2_C3D4, 32'h0,       1, -2, 1'b1, 32'h0000_0600, 4'b1001, 1'b1, 2, 3, 1'b0, 1'b0};

        // Reset state.
        rst           = 1'b1;
        global_flush  = 1'b0;
        mem_enable_in = 1'b0;
        mem_rw_in     = 1'b0;
        mem_sel_in    = 4'b0000;
        addr_in       = '0;
        mem_write_in  = '0;
        bus_ack       = 1'b0;
        bus_rdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst state", {30'b0, state_dbg}, 32'd0);
        chk("rst bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst stall", {31'b0, stall_out}, 32'd0);
        chk("rst read_out", mem_read_out, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_sel", {28'b0, bus_sel}, 32'd0);
        chk("rst bus_we", {31'b0, bus_we}, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst err", {31'b0, bus_error_out}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

        // Ack and data outside BUSY must be ignored.
        @(posedge clk); #1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        #5;
        chk("stray_ack state", {30'b0, state_dbg}, 32'd0);
        chk("stray_ack stall", {31'b0, stall_out}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        #5;
        chk("stray_ack read_out", mem_read_out, model_read);
        chk("stray_ack req", {31'b0, bus_req}, 32'd0);
        chk("stray_ack state2", {30'b0, state_dbg}, 32'd0);

        // Reset in the second BUSY cycle abandons the transaction.
        @(posedge clk); #1;
        mem_enable_in = 1'b1;
        mem_rw_in     = 1'b0;
        mem_sel_in    = 4'b1111;
        addr_in       = 32'h0000_0300;
        #5;
        chk("rst_busy issue_stall", {31'b0, stall_out}, 32'd1);
        @(posedge clk); #1;
        mem_enable_in = 1'b0;
        #5;
        chk("rst_busy req1", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #5;
        chk("rst_busy req2", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #5;
        model_read = '0;
        chk("rst_busy req", {31'b0, bus_req}, 32'd0);
        chk("rst_busy stall", {31'b0, stall_out}, 32'd0);
        chk("rst_busy read_out", mem_read_out, 32'd0);
        chk("rst_busy state", {30'b0, state_dbg}, 32'd0);

        // Normal operation resumes after the reset.
        run_op(100, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
